// File: rtl/mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mixer_pkg
// Description : Shared widths, default key colour, fade state encoding and
//               channel scaling helper for the sprite mixer.
// Revision    : 1.0 - initial release
// ============================================================================
package mixer_pkg;

    localparam int RGB_W     = 12;
    localparam int CH_W      = 4;
    localparam int LEVEL_MAX = 16;
    localparam int LEVEL_W   = 5;

    localparam logic [RGB_W-1:0] KEY_COLOR_DEFAULT = 12'hF0F;

    typedef enum logic [1:0] {
        FADE_IDLE = 2'd0,
        FADE_OUT  = 2'd1,
        FADE_HOLD = 2'd2,
        FADE_IN   = 2'd3
    } fade_state_t;

    // (c * level) >> 4 in 9 bits; level 16 is an exact pass-through.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0]    c,
                                                 input logic [LEVEL_W-1:0] level);
        return CH_W'(({5'd0, c} * {4'd0, level}) >> 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fade_ctrl
// Description : Frame-stepped fade-to-black / hold / fade-in controller that
//               produces the brightness level and fade status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fade_ctrl
    import mixer_pkg::*;
#(
    parameter int HOLD_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               fade_req,
    output logic [LEVEL_W-1:0] level,
    output logic               fade_busy,
    output logic               fade_black
);

    localparam int                 HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [LEVEL_W-1:0] LVL_FULL  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_ONE   = LEVEL_W'(1);

    fade_state_t        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               fade_busy_q;
    logic               fade_black_q;

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            FADE_IDLE: begin
                level_d = LVL_FULL;
                if (fade_req) begin
                    state_d = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    // A re-request at level 0 falls straight into HOLD.
                    if (level_q <= LVL_ONE) begin
                        level_d    = '0;
                        state_d    = FADE_HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        level_d = level_q - LVL_ONE;
                    end
                end
            end
            FADE_HOLD: begin
                level_d = '0;
                if (frame_tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = FADE_IN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end
                end
            end
            FADE_IN: begin
                if (fade_req) begin
                    state_d = FADE_OUT;
                end else if (frame_tick) begin
                    level_d = level_q + LVL_ONE;
                    if (level_q == LVL_FULL - LVL_ONE) begin
                        state_d = FADE_IDLE;
                    end
                end
            end
            default: begin
                state_d = FADE_IDLE;
                level_d = LVL_FULL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FADE_IDLE;
            level_q      <= LVL_FULL;
            hold_cnt_q   <= '0;
            fade_busy_q  <= 1'b0;
            fade_black_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            hold_cnt_q   <= hold_cnt_d;
            fade_busy_q  <= (state_d != FADE_IDLE);
            fade_black_q <= (state_d == FADE_HOLD);
        end
    end

    assign level      = level_q;
    assign fade_busy  = fade_busy_q;
    assign fade_black = fade_black_q;

endmodule
`default_nettype wire

// File: rtl/sprite_mixer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_mixer
// Description : Aligns sprite hits with ROM colour, resolves priority and
//               transparency, blanks, optionally fades, and registers VGA pins.
//               Fade feature is built only when SPRITE_MIXER_FADE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_mixer
    import mixer_pkg::*;
#(
    parameter int               N_LAYERS    = 4,
    parameter int               ROM_LAT     = 1,
    parameter logic [RGB_W-1:0] KEY_COLOR   = KEY_COLOR_DEFAULT,
    parameter int               HOLD_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      video_on,
    input  logic [N_LAYERS-1:0]       layer_hit,
    input  logic [RGB_W*N_LAYERS-1:0] layer_rgb,
    input  logic [RGB_W-1:0]          bg_rgb,
    input  logic                      frame_tick,
    input  logic                      fade_req,
    output logic [CH_W-1:0]           vga_r,
    output logic [CH_W-1:0]           vga_g,
    output logic [CH_W-1:0]           vga_b,
    output logic                      fade_busy,
    output logic                      fade_black
);

    logic [ROM_LAT-1:0][N_LAYERS-1:0] hit_pipe_q, hit_pipe_d;
    logic [ROM_LAT-1:0]               von_pipe_q, von_pipe_d;
    logic [RGB_W-1:0]                 rgb_q, rgb_d;

    logic [N_LAYERS-1:0] w_hit_dly;
    logic                w_von_dly;
    logic [N_LAYERS-1:0] w_opaque;
    logic [RGB_W-1:0]    w_pix;
    logic [LEVEL_W-1:0]  w_level;

    // Hit and video_on travel with the ROM so they meet layer_rgb/bg_rgb.
    always_comb begin
        hit_pipe_d    = hit_pipe_q;
        von_pipe_d    = von_pipe_q;
        hit_pipe_d[0] = layer_hit;
        von_pipe_d[0] = video_on;
        for (int k = 1; k < ROM_LAT; k++) begin
            hit_pipe_d[k] = hit_pipe_q[k-1];
            von_pipe_d[k] = von_pipe_q[k-1];
        end
    end

    assign w_hit_dly = hit_pipe_q[ROM_LAT-1];
    assign w_von_dly = von_pipe_q[ROM_LAT-1];

    generate
        for (genvar i = 0; i < N_LAYERS; i++) begin : g_opaque
            assign w_opaque[i] = w_hit_dly[i] && (layer_rgb[i*RGB_W +: RGB_W] != KEY_COLOR);
        end
    endgenerate

    always_comb begin
        w_pix = bg_rgb;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_pix = layer_rgb[i*RGB_W +: RGB_W];
            end
        end
        if (!w_von_dly) begin
            w_pix = '0;
        end
    end

`ifdef SPRITE_MIXER_FADE_EN
    fade_ctrl #(
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_fade_ctrl (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .fade_req   (fade_req),
        .level      (w_level),
        .fade_busy  (fade_busy),
        .fade_black (fade_black)
    );
`else
    logic unused_fade;

    assign w_level     = LEVEL_W'(LEVEL_MAX);
    assign fade_busy   = 1'b0;
    assign fade_black  = 1'b0;
    assign unused_fade = &{1'b0, fade_req, frame_tick, (HOLD_FRAMES > 0)};
`endif

    always_comb begin
        rgb_d = {scale_ch(w_pix[2*CH_W +: CH_W], w_level),
                 scale_ch(w_pix[1*CH_W +: CH_W], w_level),
                 scale_ch(w_pix[0*CH_W +: CH_W], w_level)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_pipe_q <= '0;
            von_pipe_q <= '0;
            rgb_q      <= '0;
        end else begin
            hit_pipe_q <= hit_pipe_d;
            von_pipe_q <= von_pipe_d;
            rgb_q      <= rgb_d;
        end
    end

    assign vga_r = rgb_q[2*CH_W +: CH_W];
    assign vga_g = rgb_q[1*CH_W +: CH_W];
    assign vga_b = rgb_q[0*CH_W +: CH_W];

endmodule
`default_nettype wire

// File: tb/tb_sprite_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_mixer
// Description : Self-checking bench for sprite_mixer at ROM_LAT 1 and 2; fade
//               checks follow SPRITE_MIXER_FADE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_mixer;

    localparam int HMASK = 4095;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        video_on = 1'b0;
    logic [3:0]  layer_hit = '0;
    logic [47:0] layer_rgb = '0;
    logic [11:0] bg_rgb = '0;
    logic        frame_tick = 1'b0;
    logic        fade_req = 1'b0;

    logic [3:0] r1, g1, b1, r2, g2, b2;
    logic       busy1, black1, busy2, black2;
    logic [11:0] out1, out2;

    assign out1 = {r1, g1, b1};
    assign out2 = {r2, g2, b2};

    always #5 clk = ~clk;

    sprite_mixer #(.N_LAYERS(4), .ROM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .video_on(video_on), .layer_hit(layer_hit),
        .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .frame_tick(frame_tick),
        .fade_req(fade_req), .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .fade_busy(busy1), .fade_black(black1));

    sprite_mixer #(.N_LAYERS(4), .ROM_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .video_on(video_on), .layer_hit(layer_hit),
        .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .frame_tick(frame_tick),
        .fade_req(fade_req), .vga_r(r2), .vga_g(g2), .vga_b(b2),
        .fade_busy(busy2), .fade_black(black2));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [3:0]  h_hist   [HMASK+1];
    logic        v_hist   [HMASK+1];
    logic [47:0] rgb_hist [HMASK+1];
    logic [11:0] bg_hist  [HMASK+1];

    typedef struct {
        logic [3:0]  hit;
        logic        von;
        logic [47:0] rgb;
        logic [11:0] bg;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: record what was presented, advance, then clear pulse inputs.
    task automatic clk_step();
        h_hist[cyc & HMASK]   = layer_hit;
        v_hist[cyc & HMASK]   = video_on;
        rgb_hist[cyc & HMASK] = layer_rgb;
        bg_hist[cyc & HMASK]  = bg_rgb;
        @(posedge clk);
        #1;
        cyc++;
        fade_req   = 1'b0;
        frame_tick = 1'b0;
        rst        = 1'b0;
    endtask

    function automatic logic [11:0] scl(input logic [11:0] c, input int lvl);
        int r, g, b;
        r = int'(c[11:8]) * lvl / 16;
        g = int'(c[7:4]) * lvl / 16;
        b = int'(c[3:0]) * lvl / 16;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    // Pixel on the pins after the edge closing cycle c, at full brightness.
    function automatic logic [11:0] model_pix(input int c, input int lat);
        logic [3:0]  h;
        logic [47:0] rgb;
        logic [11:0] px;
        logic        found;
        h     = h_hist[(c - lat) & HMASK];
        rgb   = rgb_hist[c & HMASK];
        px    = bg_hist[c & HMASK];
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && h[i] && rgb[i*12 +: 12] != 12'hF0F) begin
                px    = rgb[i*12 +: 12];
                found = 1'b1;
            end
        end
        if (!v_hist[(c - lat) & HMASK]) px = 12'h000;
        return px;
    endfunction

    // Level after n ticks counted from a fade request issued in IDLE.
    function automatic int lvl_model(input int n);
        if (n <= 16) return 16 - n;
        if (n < 46)  return 0;
        if (n - 46 <= 16) return n - 46;
        return 16;
    endfunction

    task automatic tick_settle(input int ticks);
        for (int t = 0; t < ticks; t++) begin
            frame_tick = 1'b1;
            clk_step();
            clk_step();
            clk_step();
        end
    endtask

    initial begin
        tbl[0] = '{4'b0011, 1'b1, {12'h000, 12'h000, 12'h0A5, 12'hF0F}, 12'h123, 12'h0A5};
        tbl[1] = '{4'b0000, 1'b1, {12'h000, 12'h000, 12'h0A5, 12'hF0F}, 12'h123, 12'h123};
        tbl[2] = '{4'b0001, 1'b0, {12'h000, 12'h000, 12'h000, 12'hFFF}, 12'h123, 12'h000};
        tbl[3] = '{4'b1111, 1'b1, {12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F}, 12'h456, 12'h456};
        tbl[4] = '{4'b1000, 1'b1, {12'h9C3, 12'h111, 12'h222, 12'h333}, 12'h456, 12'h9C3};
        tbl[5] = '{4'b0101, 1'b1, {12'h888, 12'h123, 12'h222, 12'hABC}, 12'h456, 12'hABC};
        tbl[6] = '{4'b0110, 1'b1, {12'h888, 12'h777, 12'hF0F, 12'hABC}, 12'h456, 12'h777};
        tbl[7] = '{4'b1110, 1'b1, {12'h888, 12'h777, 12'hF0E, 12'hABC}, 12'h456, 12'hF0E};

        // Reset state
        rst = 1'b1; clk_step();
        rst = 1'b1; clk_step();
        chk("reset_rgb_lat1", out1, 12'h000);
        chk("reset_rgb_lat2", out2, 12'h000);
        chk("reset_busy", {10'd0, busy1, busy2}, 12'h000);
        chk("reset_black", {10'd0, black1, black2}, 12'h000);

        // Steady-state priority, transparency and blanking table
        for (int v = 0; v < 8; v++) begin
            layer_hit = tbl[v].hit;
            video_on  = tbl[v].von;
            layer_rgb = tbl[v].rgb;
            bg_rgb    = tbl[v].bg;
            repeat (3) clk_step();
            chk($sformatf("table%0d_lat1", v), out1, tbl[v].exp);
            chk($sformatf("table%0d_lat2", v), out2, tbl[v].exp);
        end

        // Single-pixel hit pulse: one output pixel ROM_LAT+1 clocks later
        layer_hit = 4'b0000;
        video_on  = 1'b1;
        layer_rgb = {36'h0, 12'hFFF};
        bg_rgb    = 12'h000;
        repeat (4) clk_step();
        for (int k = 1; k <= 6; k++) begin
            layer_hit = (k == 1) ? 4'b0001 : 4'b0000;
            clk_step();
            chk($sformatf("pulse_lat1_k%0d", k), out1, (k == 2) ? 12'hFFF : 12'h000);
            chk($sformatf("pulse_lat2_k%0d", k), out2, (k == 3) ? 12'hFFF : 12'h000);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            layer_hit = 4'($urandom);
            video_on  = ($urandom_range(0, 7) != 0);
            for (int l = 0; l < 4; l++) begin
                layer_rgb[l*12 +: 12] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
            end
            bg_rgb = 12'($urandom);
            clk_step();
            if (i >= 3) begin
                chk("random_lat1", out1, model_pix(cyc - 1, 1));
                chk("random_lat2", out2, model_pix(cyc - 1, 2));
            end
        end

        layer_hit = 4'b0001;
        video_on  = 1'b1;
        bg_rgb    = 12'h000;
`ifdef SPRITE_MIXER_FADE_EN
        layer_rgb = {36'h0, 12'hFFF};
        repeat (3) clk_step();

        // Full fade cycle
        fade_req = 1'b1;
        clk_step();
        for (int n = 1; n <= 62; n++) begin
            tick_settle(1);
            chk($sformatf("fade_n%0d_lat1", n), out1, scl(12'hFFF, lvl_model(n)));
            chk($sformatf("fade_n%0d_lat2", n), out2, scl(12'hFFF, lvl_model(n)));
            chk($sformatf("fade_black_n%0d", n), {11'd0, black1}, {11'd0, (n >= 16 && n < 46)});
            chk($sformatf("fade_busy_n%0d", n), {11'd0, busy1}, {11'd0, (n < 62)});
        end

        // Request and tick together in IDLE: no decrement that clock
        fade_req   = 1'b1;
        frame_tick = 1'b1;
        clk_step(); clk_step(); clk_step();
        chk("req_tick_rgb", out1, 12'hFFF);
        chk("req_tick_busy", {10'd0, busy1, busy2}, 12'h003);
        tick_settle(1);
        chk("req_tick_first_dec", out1, scl(12'hFFF, 15));

        tick_settle(15);
        chk("refade_hold_rgb", out1, 12'h000);
        chk("refade_hold_black", {11'd0, black1}, 12'h001);
        tick_settle(30);
        chk("refade_in_black", {11'd0, black1}, 12'h000);
        chk("refade_in_busy", {11'd0, busy1}, 12'h001);
        tick_settle(10);
        chk("refade_lvl10", out1, scl(12'hFFF, 10));

        // Re-request in IN at level 10 continues down from there
        fade_req = 1'b1;
        clk_step(); clk_step(); clk_step();
        chk("rereq_hold_lvl", out1, scl(12'hFFF, 10));
        tick_settle(1);
        chk("rereq_lvl9_lat1", out1, scl(12'hFFF, 9));
        chk("rereq_lvl9_lat2", out2, scl(12'hFFF, 9));
        tick_settle(9);
        chk("rereq_hold_black", {10'd0, black1, black2}, 12'h003);

        // Reset mid-HOLD
        rst = 1'b1;
        clk_step();
        chk("rst_hold_rgb", out1, 12'h000);
        chk("rst_hold_busy", {10'd0, busy1, busy2}, 12'h000);
        chk("rst_hold_black", {10'd0, black1, black2}, 12'h000);
        repeat (3) clk_step();
        chk("rst_level16_lat1", out1, 12'hFFF);
        chk("rst_level16_lat2", out2, 12'hFFF);
`else
        layer_rgb = {36'h0, 12'h9C3};
        repeat (3) clk_step();
        fade_req = 1'b1;
        clk_step();
        for (int n = 1; n <= 20; n++) begin
            frame_tick = 1'b1;
            clk_step();
            clk_step();
            chk($sformatf("nofade_n%0d_lat1", n), out1, 12'h9C3);
            chk($sformatf("nofade_n%0d_lat2", n), out2, 12'h9C3);
            chk($sformatf("nofade_busy_n%0d", n), {10'd0, busy1, busy2}, 12'h000);
            chk($sformatf("nofade_black_n%0d", n), {10'd0, black1, black2}, 12'h000);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_mixer.md
# sprite_mixer

Downstream compositing stage for all sprite layers (cloud, player, tiles, …) in the VGA pipeline. Each sprite block presents a combinational hit flag and a block-ROM colour that arrives one clock later. The mixer aligns the two, resolves layer priority and transparency, and applies blanking. It also applies an optional frame-stepped fade-to-black / fade-in used on death and respawn, and drives the registered 4:4:4 VGA colour pins.

## Interface
- `N_LAYERS`, 4: number of sprite layers; index 0 is highest priority.
- `ROM_LAT`, 1: clocks from `col`/`row` to valid `layer_rgb`; range 1–3.
- `KEY_COLOR`, 12'hF0F: colour treated as transparent.
- `HOLD_FRAMES`, 30: frames held fully black between fade-out and fade-in.

- `clk`  in  1: pixel clock, shared with the sprite ROMs.
- `rst`  in  1: reset; one clock, synchronous reset, active-high.
- `video_on`  in  1: active-display flag, aligned with `col`/`row`.
- `layer_hit`  in  N_LAYERS: per-layer in-box flag, aligned with `col`/`row`.
- `layer_rgb`  in  12*N_LAYERS: per-layer ROM colour, `ROM_LAT` clocks after its hit; layer i at bits [12i+11:12i].
- `bg_rgb`  in  12: background colour, aligned with `layer_rgb`.
- `frame_tick`  in  1: one-clock pulse per frame, during vertical blanking.
- `fade_req`  in  1: one-clock request to start a fade cycle.
- `vga_r`, `vga_g`, `vga_b`  out  4 each: registered colour.
- `fade_busy`  out  1: high while the fade FSM is not IDLE.
- `fade_black`  out  1: high only in the HOLD state.

## Operation
- Alignment: `layer_hit` and `video_on` pass through a `ROM_LAT`-deep shift register. All stages reset to 0.
- Opaque test: layer i is opaque when its delayed hit is 1 and its `layer_rgb` slice is not `KEY_COLOR`.
- Priority: the lowest-index opaque layer wins. If no layer is opaque, `bg_rgb` is used.
- Blanking: if the delayed `video_on` is 0, the selected colour is forced to 12'h000 before scaling.
- Scaling:
  - Brightness `level` is 5 bits, range 0..16.
  - Each 4-bit channel becomes (c × level) >> 4, computed in 9 bits and then truncated.
  - level 16 passes the colour exactly; level 0 gives 0.
- Fade FSM (advances only on `frame_tick`):
  - IDLE: level = 16. `fade_req` moves to OUT.
  - OUT: level decrements by 1 per tick. On the tick that makes level 0, move to HOLD and clear the hold counter.
  - HOLD: level = 0. The counter increments per tick. When counter = HOLD_FRAMES−1 on a tick, move to IN.
  - IN: level increments by 1 per tick. On reaching 16, move to IDLE.
- Request handling:
  - `fade_req` in IN re-enters OUT from the current level.
  - `fade_req` in OUT or HOLD is ignored.
  - `fade_req` and `frame_tick` in the same clock in IDLE: enter OUT, but do not decrement that clock.
- Reset mid-fade: returns to IDLE with level 16 on the next edge.

## Timing
- The pixel from `col`/`row` at clock t appears on `vga_*` after clock t+ROM_LAT+1.
- The output register is the only stage after the ROM alignment.
- `fade_busy` and `fade_black` are registered FSM decodes; they change the clock after the transition.
- `level` changes take effect on the next pixel. Because ticks occur in blanking, no visible tearing results.
- Reset values: `vga_*` = 0, `fade_busy` = 0, `fade_black` = 0, level = 16, state IDLE, hold counter = 0.

## Configuration
- `SPRITE_MIXER_FADE_EN` defined: the fade FSM, level scaling and status outputs are built as described above.
- `SPRITE_MIXER_FADE_EN` undefined:
  - level is the constant 16, so the colour passes unscaled with identical latency.
  - `fade_busy` and `fade_black` are tied to 0.
  - `fade_req` and `frame_tick` are ignored.

## Structure
- Shared package `mixer_pkg` holds:
  - `RGB_W` = 12, `CH_W` = 4, `LEVEL_MAX` = 16;
  - the default `KEY_COLOR`;
  - the fade state enum: IDLE, OUT, HOLD, IN.
- Sub-module `fade_ctrl` contains the FSM, level register and hold counter. It outputs `level`, `fade_busy` and `fade_black`, and is instantiated only under the macro.
- Priority select, transparency compare and scaling stay in `sprite_mixer`.

## Test plan
- Priority and transparency:
  - Stimulus: `ROM_LAT`=1; hits = 4'b0011, layer0 rgb = F0F, layer1 rgb = 0A5, bg = 123.
  - Required: `vga_*` = 0/A/5 two clocks later.
  - Follow-up: with hits = 0, output = 1/2/3.
- Blanking: `video_on` = 0 with layer0 opaque rgb FFF → `vga_*` = 0 at the aligned output clock.
- Latency: a single-pixel hit pulse with `ROM_LAT`=2 → exactly one output pixel, 3 clocks after the pulse.
- Full fade:
  - Stimulus: `fade_req`, then ticks; rgb = FFF.
  - Required: after 8 ticks the output is 7/7/7 ((15×8)>>4); after 16 ticks it is 0 and `fade_black`=1.
  - Required: after 30 further ticks, IN begins; after 16 more ticks the output is F/F/F and `fade_busy`=0.
- Re-request and reset:
  - `fade_req` in IN at level 10 → the next tick gives level 9 (state OUT).
  - `rst` in HOLD → the next clock gives level 16, `fade_busy`=0, `fade_black`=0.
- Macro off: `fade_req` plus 20 ticks → output unscaled throughout; `fade_busy` stays 0.
